// File: rtl/data_ram_streamer.sv
// Avalon-MM read master streaming a contiguous block of data RAM words out as valid/ready.
// Optional build macro DATA_RAM_STREAMER_BYTESWAP_EN reverses the byte order of every streamed word.
module data_ram_streamer #(
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_chipselect,
    output logic [3:0]        avm_byteenable,
    input  logic [DATA_W-1:0] avm_readdata,
    output logic [DATA_W-1:0] st_data,
    output logic              st_valid,
    input  logic              st_ready,
    output logic              st_last
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t              state, state_nxt;
    logic [ADDR_W:0]     reads_left, words_left;
    logic [ADDR_W-1:0]   addr_q;
    logic [READ_LATENCY-1:0] rd_pipe;
    logic [CNT_W-1:0]    inflight, fifo_count;
    logic [CNT_W:0]      credit_used;
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [DATA_W-1:0]   fifo_mem [FIFO_DEPTH];
    logic [DATA_W-1:0]   push_data;
    logic                accept, issue, push, pop, credit;

    // Stream handshake: a word moves when st_valid & st_ready; the head word and
    // st_last hold still while st_valid & ~st_ready.
    assign st_valid = (fifo_count != '0);
    assign pop      = st_valid && st_ready;
    assign st_data  = st_valid ? fifo_mem[rd_ptr] : '0;
    assign st_last  = st_valid && (words_left == (ADDR_W+1)'(1));

    // A read returns exactly READ_LATENCY cycles after issue; the pipe tracks when to push.
    assign push        = rd_pipe[READ_LATENCY-1];
    assign credit_used = {1'b0, inflight} + {1'b0, fifo_count};
    assign credit      = (credit_used < (CNT_W+1)'(FIFO_DEPTH));

    assign avm_address    = addr_q;
    assign avm_chipselect = issue;
    assign avm_byteenable = 4'hF;

`ifdef DATA_RAM_STREAMER_BYTESWAP_EN
    always_comb begin
        push_data = avm_readdata;
        for (int b = 0; b < DATA_W/8; b++) begin
            push_data[8*b +: 8] = avm_readdata[DATA_W-8-8*b +: 8];
        end
    end
`else
    assign push_data = avm_readdata;
`endif

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        issue     = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = (length == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                busy  = 1'b1;
                issue = (reads_left != '0) && credit;
                if (issue && (reads_left == (ADDR_W+1)'(1))) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (pop && (words_left == (ADDR_W+1)'(1))) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            reads_left <= '0;
            words_left <= '0;
            addr_q     <= '0;
            rd_pipe    <= '0;
            inflight   <= '0;
            fifo_count <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else begin
            state   <= state_nxt;
            rd_pipe <= (rd_pipe << 1) | READ_LATENCY'(issue);

            if (accept) begin
                reads_left <= length;
                words_left <= length;
                addr_q     <= base_addr;
            end else begin
                // Address wraps modulo 2^ADDR_W by natural overflow.
                if (issue) begin
                    reads_left <= reads_left - 1'b1;
                    addr_q     <= addr_q + 1'b1;
                end
                if (pop) begin
                    words_left <= words_left - 1'b1;
                end
            end

            case ({issue, push})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: ;
            endcase

            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: ;
            endcase

            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= push_data;
        end
    end

    // The credit check guarantees room for every returning word.
    fifo_overflow: assert property (@(posedge clk) disable iff (!reset_n)
        !(push && !pop && (fifo_count == CNT_W'(FIFO_DEPTH))));

endmodule

// File: tb/tb_data_ram_streamer.sv
// Self-checking bench for data_ram_streamer: RAM model, scoreboard against a queue-based reference.
// Honours DATA_RAM_STREAMER_BYTESWAP_EN when computing expected stream words.
module tb_data_ram_streamer;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
`ifdef DATA_RAM_STREAMER_BYTESWAP_EN
    localparam logic [31:0] SWAP_EXPECT = 32'h44332211;
`else
    localparam logic [31:0] SWAP_EXPECT = 32'h11223344;
`endif

    logic              clk;
    logic              reset_n;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   length;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] avm_address;
    logic              avm_chipselect;
    logic [3:0]        avm_byteenable;
    logic [DATA_W-1:0] avm_readdata;
    logic [DATA_W-1:0] st_data;
    logic              st_valid;
    logic              st_ready;
    logic              st_last;

    data_ram_streamer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .base_addr      (base_addr),
        .length         (length),
        .busy           (busy),
        .done           (done),
        .avm_address    (avm_address),
        .avm_chipselect (avm_chipselect),
        .avm_byteenable (avm_byteenable),
        .avm_readdata   (avm_readdata),
        .st_data        (st_data),
        .st_valid       (st_valid),
        .st_ready       (st_ready),
        .st_last        (st_last)
    );

    // ---------------- clock / cycle counter ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int gcyc = 0;
    always @(posedge clk) gcyc <= gcyc + 1;

    // ---------------- RAM model: data one cycle after the read ----------------
    logic [31:0] ram [1024];
    logic [31:0] rd_data_q;
    always @(posedge clk) rd_data_q <= avm_chipselect ? ram[avm_address] : 32'hDEAD_BEEF;
    assign avm_readdata = rd_data_q;

    // ---------------- scoreboard state ----------------
    logic [31:0]       exp_q[$];
    logic              exp_last_q[$];
    logic [ADDR_W-1:0] addr_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int t0, rel;
    int hs_cnt, cs_cnt, busy_cnt, max_out, done_cyc, first_hs, last_hs;
    bit mon_en = 0;
    bit prev_stall = 0;
    logic [31:0] prev_data, last_data;
    logic        prev_last;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_word(input logic [31:0] w);
`ifdef DATA_RAM_STREAMER_BYTESWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    function automatic logic ready_for(input int mode, input int k);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (k % 2) == 0;
        return 1'($urandom_range(0, 1));
    endfunction

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            rel = gcyc - t0;
            if (prev_stall) begin
                check("stall_hold_valid", st_valid, 1);
                check("stall_hold_data", st_data, prev_data);
                check("stall_hold_last", st_last, prev_last);
            end
            if (avm_chipselect) begin
                cs_cnt++;
                check("read_in_budget", addr_q.size() > 0, 1);
                if (addr_q.size() > 0) check("read_addr", avm_address, addr_q.pop_front());
                if (cs_cnt - hs_cnt > max_out) max_out = cs_cnt - hs_cnt;
            end
            if (st_valid && st_ready) begin
                hs_cnt++;
                last_data = st_data;
                if (first_hs < 0) first_hs = rel;
                last_hs = rel;
                check("word_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    check("st_data", st_data, exp_q.pop_front());
                    check("st_last", st_last, exp_last_q.pop_front());
                end
            end
            if (busy) busy_cnt++;
            if (done) begin
                check("busy_low_in_done", busy, 0);
                if (done_cyc < 0) done_cyc = rel;
            end
            prev_stall = st_valid && !st_ready;
            prev_data  = st_data;
            prev_last  = st_last;
        end else begin
            prev_stall = 0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setup_job(input int base, input int len);
        exp_q.delete();
        exp_last_q.delete();
        addr_q.delete();
        for (int i = 0; i < len; i++) begin
            addr_q.push_back(ADDR_W'((base + i) % 1024));
            exp_q.push_back(model_word(ram[(base + i) % 1024]));
            exp_last_q.push_back(i == len - 1);
        end
        hs_cnt = 0; cs_cnt = 0; busy_cnt = 0; max_out = 0;
        done_cyc = -1; first_hs = -1; last_hs = -1;
    endtask

    task automatic run_job(input int base, input int len, input int mode, input bit spam,
                           input int exp_done);
        setup_job(base, len);
        base_addr = ADDR_W'(base);
        length    = (ADDR_W+1)'(len);
        start     = 1'b1;
        st_ready  = ready_for(mode, 0);
        t0        = gcyc;
        mon_en    = 1'b1;
        tick();
        for (int k = 1; k < 3000 && done_cyc < 0; k++) begin
            start = spam && k >= 2 && k <= 4;
            if (start) begin
                base_addr = 10'h200;
                length    = 11'd5;
            end else begin
                base_addr = ADDR_W'($urandom);
                length    = (ADDR_W+1)'($urandom);
            end
            st_ready = ready_for(mode, k);
            tick();
        end
        start = 1'b0;
        check("done_seen", done_cyc >= 0, 1);
        if (exp_done >= 0) check("done_cycle", done_cyc, exp_done);
        check("handshakes", hs_cnt, len);
        check("reads", cs_cnt, len);
        check("leftover_words", exp_q.size(), 0);
        check("busy_cycles", busy_cnt, done_cyc - 1);
        check("outstanding_le_depth", max_out <= DEPTH, 1);
        if (mode == 0 && len > 0) begin
            check("first_word_cycle", first_hs, 3);
            check("last_word_cycle", last_hs, len + 2);
        end
    endtask

    task automatic check_reset_vals();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_chipselect", avm_chipselect, 0);
        check("rst_address", avm_address, 0);
        check("rst_byteenable", avm_byteenable, 4'hF);
        check("rst_st_valid", st_valid, 0);
        check("rst_st_last", st_last, 0);
        check("rst_st_data", st_data, 0);
    endtask

    // ---------------- test vectors ----------------
    typedef struct {
        int base;
        int len;
        int mode;
        bit spam;
        int exp_done;
    } vec_t;
    vec_t vecs[7];

    int quiet_bad;

    initial begin
        vecs[0] = '{base: 'h010, len: 8,  mode: 0, spam: 0, exp_done: 11};
        vecs[1] = '{base: 'h3FE, len: 4,  mode: 0, spam: 0, exp_done: 7};
        vecs[2] = '{base: 'h000, len: 16, mode: 1, spam: 0, exp_done: -1};
        vecs[3] = '{base: 'h123, len: 0,  mode: 0, spam: 0, exp_done: 1};
        vecs[4] = '{base: 'h050, len: 6,  mode: 0, spam: 1, exp_done: 9};
        vecs[5] = '{base: 'h3FC, len: 1,  mode: 0, spam: 0, exp_done: 4};
        vecs[6] = '{base: 'h3F0, len: 1100, mode: 0, spam: 0, exp_done: 1103};

        reset_n = 1'b0; start = 1'b0; base_addr = '0; length = '0; st_ready = 1'b0;
        for (int i = 0; i < 1024; i++) ram[i] = i;
        repeat (3) tick();
        check_reset_vals();
        reset_n = 1'b1;
        tick();

        for (int v = 0; v < 7; v++) begin
            run_job(vecs[v].base, vecs[v].len, vecs[v].mode, vecs[v].spam, vecs[v].exp_done);
        end

        // Byte order of a known word
        ram['h080] = 32'h11223344;
        run_job('h080, 1, 0, 0, 4);
        check("byteswap_word", last_data, SWAP_EXPECT);

        // Reset in the middle of a burst, then a short restart
        setup_job('h100, 10);
        base_addr = 10'h100; length = 11'd10; start = 1'b1; st_ready = 1'b1;
        t0 = gcyc; mon_en = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        reset_n = 1'b0;
        tick();
        mon_en = 1'b0;
        check("words_before_reset", hs_cnt, 3);
        check_reset_vals();
        tick();
        reset_n = 1'b1;
        quiet_bad = 0;
        for (int k = 0; k < 6; k++) begin
            if (st_valid || avm_chipselect || busy || done) quiet_bad++;
            tick();
        end
        check("post_reset_quiet", quiet_bad, 0);
        run_job('h2A0, 2, 0, 0, 5);

        // Randomised jobs with random backpressure
        for (int i = 0; i < 1024; i++) ram[i] = $urandom;
        for (int r = 0; r < 8; r++) begin
            run_job($urandom_range(0, 1023), $urandom_range(1, 40), 2, 0, -1);
        end

        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
